// File: rtl/swap_rotate_bank_pkg.sv
// Shared op-code constants, FSM state encoding and index range helper
// for the swap/rotate register bank.
package swap_rotate_pkg;

  localparam logic [1:0] OP_SWAP_TEMP = 2'b00;
  localparam logic [1:0] OP_ROT_L     = 2'b01;
  localparam logic [1:0] OP_ROT_R     = 2'b10;
  localparam logic [1:0] OP_SWAP_NB   = 2'b11;

  typedef enum logic [2:0] {IDLE, SAVE, MOVE, RESTORE, EXEC} st_t;

  // Runtime range check, kept generic so power-of-two depths stay warning-free.
  function automatic logic idx_in_range(input int unsigned idx, input int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/swap_rotate_bank_if.sv
// Command port of the swap/rotate bank: valid/ready handshake plus
// completion (done) and rejection (err) pulses.
interface swap_rotate_bank_if #(
  parameter int DEPTH = 4
);
  localparam int IDXW = $clog2(DEPTH);

  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_code;
  logic [IDXW-1:0] idx_a;
  logic [IDXW-1:0] idx_b;
  logic            done;
  logic            err;

  modport master (output op_valid, op_code, idx_a, idx_b,
                  input  op_ready, done, err);
  modport slave  (input  op_valid, op_code, idx_a, idx_b,
                  output op_ready, done, err);
endinterface

// File: rtl/swap_rotate_bank_ctrl.sv
// Command FSM for the swap/rotate bank: handshake, index range checks,
// done/err pulses and per-state write strobes for the register bank.
module swap_rotate_bank_ctrl
  import swap_rotate_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  swap_rotate_bank_if.slave        cmd,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  output logic                     ld_we,
  output logic                     temp_we,
  output logic                     mv_we,
  output logic                     rs_we,
  output logic                     nb_we,
  output logic                     rl_we,
  output logic                     rr_we,
  output logic [$clog2(DEPTH)-1:0] a_q,
  output logic [$clog2(DEPTH)-1:0] b_q
);
  st_t        state;
  logic [1:0] op_q;
  logic       cmd_ok;
  logic       ld_ok;

  assign cmd_ok = idx_in_range(32'(cmd.idx_a), 32'(DEPTH)) &&
                  idx_in_range(32'(cmd.idx_b), 32'(DEPTH));
  assign ld_ok  = idx_in_range(32'(load_idx), 32'(DEPTH));

  assign cmd.op_ready = (state == IDLE);

  // A load in IDLE takes priority; the command waits with op_ready still high.
  assign ld_we   = (state == IDLE) && load_en && ld_ok;
  assign temp_we = (state == SAVE);
  assign mv_we   = (state == MOVE);
  assign rs_we   = (state == RESTORE);
  assign nb_we   = (state == EXEC) && (op_q == OP_SWAP_NB);
  assign rl_we   = (state == EXEC) && (op_q == OP_ROT_L);
  assign rr_we   = (state == EXEC) && (op_q == OP_ROT_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_SWAP_TEMP;
      a_q      <= '0;
      b_q      <= '0;
      cmd.done <= 1'b0;
      cmd.err  <= 1'b0;
    end else begin
      cmd.done <= 1'b0;
      cmd.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            if (!ld_ok) cmd.err <= 1'b1;
          end else if (cmd.op_valid) begin
            if (!cmd_ok) begin
              cmd.err <= 1'b1;
            end else begin
              op_q  <= cmd.op_code;
              a_q   <= cmd.idx_a;
              b_q   <= cmd.idx_b;
              state <= (cmd.op_code == OP_SWAP_TEMP) ? SAVE : EXEC;
            end
          end
        end
        SAVE:    state <= MOVE;
        MOVE:    state <= RESTORE;
        RESTORE: begin
          cmd.done <= 1'b1;
          state    <= IDLE;
        end
        EXEC: begin
          cmd.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/swap_rotate_bank.sv
// DEPTH x WIDTH register bank with temp-register swap, nonblocking swap and
// rotate commands. Optional counters enabled by SWAP_ROTATE_STATS_EN.
module swap_rotate_bank
  import swap_rotate_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  swap_rotate_bank_if.slave        cmd,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [WIDTH-1:0]         load_data,
  output logic [DEPTH*WIDTH-1:0]   bank
`ifdef SWAP_ROTATE_STATS_EN
  ,
  output logic [15:0]              op_count,
  output logic [7:0]               err_count
`endif
);
  localparam int IDXW = $clog2(DEPTH);

  logic [WIDTH-1:0] r [DEPTH];
  logic [WIDTH-1:0] temp;
  logic             ld_we, temp_we, mv_we, rs_we, nb_we, rl_we, rr_we;
  logic [IDXW-1:0]  a_q, b_q;

  swap_rotate_bank_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .load_en  (load_en),
    .load_idx (load_idx),
    .ld_we    (ld_we),
    .temp_we  (temp_we),
    .mv_we    (mv_we),
    .rs_we    (rs_we),
    .nb_we    (nb_we),
    .rl_we    (rl_we),
    .rr_we    (rr_we),
    .a_q      (a_q),
    .b_q      (b_q)
  );

  // Strobes are mutually exclusive: at most one bank update per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= WIDTH'(i);
      temp <= '0;
    end else begin
      if (ld_we)   r[load_idx] <= load_data;
      if (temp_we) temp        <= r[a_q];
      if (mv_we)   r[a_q]      <= r[b_q];
      if (rs_we)   r[b_q]      <= temp;
      if (nb_we) begin
        r[a_q] <= r[b_q];
        r[b_q] <= r[a_q];
      end
      if (rl_we) for (int i = 0; i < DEPTH; i++) r[i] <= r[(i + 1) % DEPTH];
      if (rr_we) for (int i = 0; i < DEPTH; i++) r[i] <= r[(i + DEPTH - 1) % DEPTH];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    assign bank[g*WIDTH +: WIDTH] = r[g];
  end

`ifdef SWAP_ROTATE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      err_count <= '0;
    end else begin
      if (cmd.done) op_count <= op_count + 16'd1;
      if (cmd.err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_swap_rotate_bank.sv
// Self-checking bench: directed steps plus randomized commands against a
// queue-based reference model (DEPTH=4 main instance, DEPTH=5 range checks).
module tb_swap_rotate_bank;
  localparam logic [1:0] C_ST = 2'b00, C_RL = 2'b01, C_RR = 2'b10, C_NB = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ld4, ld5;
  logic [1:0]  li4;
  logic [2:0]  li5;
  logic [3:0]  lv4, lv5;
  logic [15:0] bank4;
  logic [19:0] bank5;
`ifdef SWAP_ROTATE_STATS_EN
  logic [15:0] oc4, oc5;
  logic [7:0]  ec4, ec5;
`endif

  swap_rotate_bank_if #(.DEPTH(4)) c4 ();
  swap_rotate_bank_if #(.DEPTH(5)) c5 ();

  swap_rotate_bank #(.WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(c4), .load_en(ld4), .load_idx(li4),
    .load_data(lv4), .bank(bank4)
`ifdef SWAP_ROTATE_STATS_EN
    , .op_count(oc4), .err_count(ec4)
`endif
  );

  swap_rotate_bank #(.WIDTH(4), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .cmd(c5), .load_en(ld5), .load_idx(li5),
    .load_data(lv5), .bank(bank5)
`ifdef SWAP_ROTATE_STATS_EN
    , .op_count(oc5), .err_count(ec5)
`endif
  );

  int n_asserts = 0;
  int n_fail = 0;
  int unsigned mq[$];
  int exp_ops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mbank();
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) b[i*4 +: 4] = 4'(mq[i]);
    return b;
  endfunction

  function automatic void model_reset();
    mq = {0, 1, 2, 3};
    exp_ops = 0;
  endfunction

  // Reference semantics: swaps exchange two entries, rotates move the queue head/tail.
  function automatic void model_apply(input logic [1:0] op, input int a, input int b);
    int unsigned t;
    case (op)
      C_RL: mq.push_back(mq.pop_front());
      C_RR: mq.push_front(mq.pop_back());
      default: begin
        t = mq[a]; mq[a] = mq[b]; mq[b] = t;
      end
    endcase
    exp_ops++;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run4(input string tag, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    int cyc, lat;
    bit busy_ok;
    lat = (op == C_ST) ? 3 : 1;
    c4.op_valid = 1'b1; c4.op_code = op; c4.idx_a = a; c4.idx_b = b;
    tick();
    c4.op_valid = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (c4.done !== 1'b1 && cyc < 10) begin
      if (c4.op_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(lat));
    chk({tag, ".busy"}, 64'(busy_ok), 64'(1));
    chk({tag, ".ready_after"}, 64'(c4.op_ready), 64'(1));
    model_apply(op, int'(a), int'(b));
    chk({tag, ".bank"}, 64'(bank4), 64'(mbank()));
    tick();
    chk({tag, ".done_one_cycle"}, 64'(c4.done), 64'(0));
  endtask

  initial begin
    int cyc;
    bit done_seen;
    logic [1:0] ra, rb, rop, rli;
    logic [3:0] rlv;

    ld4 = 1'b0; li4 = '0; lv4 = '0; ld5 = 1'b0; li5 = '0; lv5 = '0;
    c4.op_valid = 1'b0; c4.op_code = '0; c4.idx_a = '0; c4.idx_b = '0;
    c5.op_valid = 1'b0; c5.op_code = '0; c5.idx_a = '0; c5.idx_b = '0;
    model_reset();

    // Reset values
    tick(); tick();
    chk("reset.bank_in_reset", 64'(bank4), 64'h3210);
    rst_n = 1'b1;
    tick();
    chk("reset.bank4", 64'(bank4), 64'h3210);
    chk("reset.bank5", 64'(bank5), 64'h43210);
    chk("reset.ready", 64'(c4.op_ready), 64'(1));
    chk("reset.done", 64'(c4.done), 64'(0));
    chk("reset.err", 64'(c4.err), 64'(0));

    // Temp-register swap with explicit timing
    run4("swap_temp_0_3", C_ST, 2'd0, 2'd3);
    chk("swap_temp_0_3.const", 64'(bank4), 64'h0213);

    do_reset();
    run4("swap_nb_1_2", C_NB, 2'd1, 2'd2);
    chk("swap_nb_1_2.const", 64'(bank4), 64'h3120);
    run4("rot_l", C_RL, 2'd0, 2'd0);
    chk("rot_l.const", 64'(bank4), 64'h0312);
    run4("rot_r", C_RR, 2'd0, 2'd0);
    chk("rot_r.const", 64'(bank4), 64'h3120);

    // Same-index swaps keep full latency and leave values alone
    run4("swap_temp_same", C_ST, 2'd2, 2'd2);
    chk("swap_temp_same.const", 64'(bank4), 64'h3120);
    run4("swap_nb_same", C_NB, 2'd3, 2'd3);
    chk("swap_nb_same.const", 64'(bank4), 64'h3120);

    // DEPTH=5: out-of-range command index
    c5.op_valid = 1'b1; c5.op_code = C_ST; c5.idx_a = 3'd0; c5.idx_b = 3'd6;
    tick();
    c5.op_valid = 1'b0;
    chk("d5_bad_idx.err", 64'(c5.err), 64'(1));
    chk("d5_bad_idx.ready", 64'(c5.op_ready), 64'(1));
    chk("d5_bad_idx.bank", 64'(bank5), 64'h43210);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (c5.done === 1'b1) done_seen = 1'b1;
    end
    chk("d5_bad_idx.no_done", 64'(done_seen), 64'(0));
    chk("d5_bad_idx.err_pulse", 64'(c5.err), 64'(0));

    // DEPTH=5: out-of-range load
    ld5 = 1'b1; li5 = 3'd5; lv5 = 4'hF;
    tick();
    ld5 = 1'b0;
    chk("d5_bad_load.err", 64'(c5.err), 64'(1));
    chk("d5_bad_load.bank", 64'(bank5), 64'h43210);

    // DEPTH=5: rotate left wraps across a non-power-of-two depth
    c5.op_valid = 1'b1; c5.op_code = C_RL; c5.idx_a = 3'd0; c5.idx_b = 3'd0;
    tick();
    c5.op_valid = 1'b0;
    chk("d5_rot_l.busy", 64'(c5.op_ready), 64'(0));
    tick();
    chk("d5_rot_l.done", 64'(c5.done), 64'(1));
    chk("d5_rot_l.bank", 64'(bank5), 64'h04321);

    // Reset in the middle of a temp swap
    do_reset();
    c4.op_valid = 1'b1; c4.op_code = C_ST; c4.idx_a = 2'd0; c4.idx_b = 2'd1;
    tick();
    c4.op_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_reset.bank", 64'(bank4), 64'h3210);
    chk("mid_reset.idle", 64'(c4.op_ready), 64'(1));
    #2;
    rst_n = 1'b1;
    model_reset();
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (c4.done === 1'b1) done_seen = 1'b1;
    end
    chk("mid_reset.no_done", 64'(done_seen), 64'(0));
    chk("mid_reset.bank_after", 64'(bank4), 64'(mbank()));

    // Load collides with a pending command: load first, command next edge
    ld4 = 1'b1; li4 = 2'd1; lv4 = 4'hA;
    c4.op_valid = 1'b1; c4.op_code = C_RL; c4.idx_a = 2'd0; c4.idx_b = 2'd0;
    tick();
    ld4 = 1'b0;
    mq[1] = 4'hA;
    chk("load_win.ready", 64'(c4.op_ready), 64'(1));
    chk("load_win.bank", 64'(bank4), 64'(mbank()));
    chk("load_win.err", 64'(c4.err), 64'(0));
`ifdef SWAP_ROTATE_STATS_EN
    chk("load_win.op_count", 64'(oc4), 64'(exp_ops));
`endif
    tick();
    c4.op_valid = 1'b0;
    chk("load_win.accepted", 64'(c4.op_ready), 64'(0));
    tick();
    chk("load_win.done", 64'(c4.done), 64'(1));
    model_apply(C_RL, 0, 0);
    chk("load_win.rot", 64'(bank4), 64'(mbank()));

    // op_valid held across done: next command accepted at first ready edge
    c4.op_valid = 1'b1; c4.op_code = C_NB; c4.idx_a = 2'd0; c4.idx_b = 2'd3;
    tick();
    tick();
    chk("held.done1", 64'(c4.done), 64'(1));
    model_apply(C_NB, 0, 3);
    c4.op_code = C_RR;
    tick();
    c4.op_valid = 1'b0;
    chk("held.accept2", 64'(c4.op_ready), 64'(0));
    chk("held.done_gap", 64'(c4.done), 64'(0));
    tick();
    chk("held.done2", 64'(c4.done), 64'(1));
    model_apply(C_RR, 0, 0);
    chk("held.bank", 64'(bank4), 64'(mbank()));
    tick();

    // Randomized commands and loads against the model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 2'($urandom_range(0, 3));
      rb  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        rli = 2'($urandom_range(0, 3));
        rlv = 4'($urandom_range(0, 15));
        ld4 = 1'b1; li4 = rli; lv4 = rlv;
        tick();
        ld4 = 1'b0;
        mq[rli] = int'(rlv);
        chk("rand.load", 64'(bank4), 64'(mbank()));
      end
      run4("rand.cmd", rop, ra, rb);
    end

`ifdef SWAP_ROTATE_STATS_EN
    chk("stats.op_count4", 64'(oc4), 64'(exp_ops));
    chk("stats.err_count4", 64'(ec4), 64'(0));
    chk("stats.err_count5", 64'(ec5), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_rotate_bank.md
Name: swap_rotate_bank

Overview:
- Parametrised successor to the two-register swap block.
- Holds DEPTH registers of WIDTH bits.
- Executes commanded operations:
  - multi-cycle pair swap through a single temp register (blocking-style sequence);
  - single-cycle nonblocking pair swap;
  - whole-bank rotate left/right.
- Sits as a teaching/demo datapath driven by a testbench or small controller over a valid/ready command port.

Parameters:
- WIDTH, 4, bits per register
- DEPTH, 4, number of registers (2..16)
- IDXW, $clog2(DEPTH), index width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  write load_data into r[load_idx]; honoured only when op_ready=1
- load_idx  in  IDXW  load target index
- load_data  in  WIDTH  load value
- op_valid  in  1  command valid
- op_ready  out  1  block idle, can accept a command
- op_code  in  2  00 SWAP_TEMP, 01 ROT_L, 10 ROT_R, 11 SWAP_NB
- idx_a  in  IDXW  first swap index
- idx_b  in  IDXW  second swap index
- done  out  1  one-cycle pulse on command completion
- err  out  1  one-cycle pulse: command rejected
- bank  out  DEPTH*WIDTH  flattened registers; r[0] in bits [WIDTH-1:0]

Behaviour:
- Reset (async, rst_n=0):
  - r[i] = i truncated to WIDTH; temp=0; state=IDLE; done=0; err=0.
  - op_ready goes to 1 once reset deasserts.
- Handshake:
  - op_ready = (state==IDLE).
  - A command is accepted at an edge with op_valid&&op_ready; idx_a/idx_b/op_code are latched at that edge.
- Load:
  - In IDLE with load_en=1, r[load_idx] is written at the edge.
  - If load_en and command acceptance coincide, the load wins and the command is not accepted (op_ready stays 1; the master must hold op_valid).
  - load_idx >= DEPTH: write ignored, err pulses.
- FSM states: IDLE, SAVE, MOVE, RESTORE, EXEC. Accept edge = T.
  - SWAP_TEMP: IDLE -> SAVE.
    - T+1: temp<=r[a], ->MOVE.
    - T+2: r[a]<=r[b], ->RESTORE.
    - T+3: r[b]<=temp, done<=1, ->IDLE.
    - done visible T+3..T+4; op_ready=0 from T to T+3.
  - ROT_L / ROT_R / SWAP_NB: IDLE -> EXEC; T+1: operate, done<=1, ->IDLE.
    - ROT_L: r[i]<=r[(i+1)%DEPTH].
    - ROT_R: r[i]<=r[(i-1+DEPTH)%DEPTH].
    - SWAP_NB: r[a]<=r[b] and r[b]<=r[a] in the same edge.
- Boundaries:
  - idx_a==idx_b: full latency still runs; values unchanged; done pulses.
  - idx_a or idx_b >= DEPTH (non-power-of-2 DEPTH): command rejected at the accept edge; err pulses T+1; stays IDLE; no register change; no done.
  - Rotate with DEPTH=2 is equivalent to a swap of r[0], r[1].
  - Reset mid-operation: immediately returns to IDLE with reset values; no done.
  - op_valid held after done: a new command is accepted at the first edge op_ready=1.
- bank is a direct register view, with no output latency.

Optional Feature:
- Macro: SWAP_ROTATE_STATS_EN
- Defined:
  - Adds output op_count [15:0]: increments on every done pulse, wraps at 0xFFFF->0, reset 0.
  - Adds output err_count [7:0]: increments on every err pulse, saturates at 0xFF.
- Undefined: neither port nor the counters exist.

Decomposition:
- Package swap_rotate_pkg holds:
  - op_code constants OP_SWAP_TEMP, OP_ROT_L, OP_ROT_R, OP_SWAP_NB;
  - state encoding typedef st_t {IDLE, SAVE, MOVE, RESTORE, EXEC}.
- One sub-module is natural: swap_rotate_ctrl (FSM, handshake, done/err generation, index range check), driving write enables into the register bank held in the top.

Test Plan:
- Reset, DEPTH=4, WIDTH=4 -> bank=0x3210, op_ready=1, done=0, err=0.
- SWAP_TEMP a=0, b=3 from reset -> op_ready low 3 cycles; bank=0x0213 at T+3; done single pulse at T+3.
- SWAP_NB a=1, b=2, then ROT_L, then ROT_R -> 0x3120, 0x0312, 0x3120; each done at T+1, op_ready low 1 cycle.
- SWAP_TEMP a=2, b=2 -> bank unchanged, done at T+3. DEPTH=5 with idx_b=6 -> err pulse, no done, bank unchanged.
- Assert rst_n=0 at T+2 of a SWAP_TEMP -> bank returns to reset values, state IDLE, no done pulse.
- load_en and op_valid together in IDLE (load r[1]=0xA) -> load applied, command accepted the next cycle; with SWAP_ROTATE_STATS_EN, op_count increments only on done.
